// File: rtl/uart_axis_core_if.sv
// Byte stream interface shared by the UART transmit and receive paths.
//   tdata  : stream data word
//   tvalid : producer has a word on tdata
//   tready : consumer accepts the word this cycle
// master modport is the producer side, slave modport the consumer side.
interface uart_axis_core_if #(
  parameter int unsigned DataWidth = 8
);
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_axis_core.sv
// Full-duplex UART core with byte-stream interfaces.
// Frame: 1 start bit (0), DataWidth data bits LSB first, 1 stop bit (1).
// Bit period is prescale_i*8 clocks (prescale_i = 0 behaves as 1). The prescale value is
// re-sampled at the start of every bit.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   prescale_i      bit-period prescaler, shared by TX and RX
//   tx_axis_io      slave stream: bytes to transmit (tready high only when TX idle)
//   txd_o           serial output, idles high
//   tx_busy_o       TX frame in progress
//   rxd_i           serial input, idles high
//   rx_axis_io      master stream: received bytes, tvalid held until taken
//   rx_busy_o       RX frame in progress
//   overrun_error_o 1-cycle pulse: word completed while previous word still pending
//   frame_error_o   1-cycle pulse: stop bit sampled low, word dropped
//
// Build option UART_RX_SYNC_EN: when defined, rxd_i passes a 2-flop synchronizer (reset to 1)
// before the receiver; otherwise it is registered once and assumed already in the clk_i domain.
module uart_axis_core #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [15:0]             prescale_i,
  uart_axis_core_if.slave         tx_axis_io,
  output logic                    txd_o,
  output logic                    tx_busy_o,
  input  logic                    rxd_i,
  uart_axis_core_if.master        rx_axis_io,
  output logic                    rx_busy_o,
  output logic                    overrun_error_o,
  output logic                    frame_error_o
);

  localparam int unsigned CntW = 19;
  localparam int unsigned IdxW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DataWidth - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bit timing
  logic [15:0]     prescale_eff;
  logic [CntW-1:0] bit_len;
  logic [CntW-1:0] half_len;

  assign prescale_eff = (prescale_i == 16'd0) ? 16'd1 : prescale_i;
  assign bit_len      = {prescale_eff, 3'b000};
  assign half_len     = {1'b0, prescale_eff, 2'b00};

  // ---------------------------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------------------------
  state_e               tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
  logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_txd_q, tx_txd_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_ready_q, tx_ready_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_txd_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_txd_q   <= tx_txd_d;
      tx_busy_q  <= tx_busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_txd_d   = tx_txd_q;
    tx_busy_d  = tx_busy_q;

    unique case (tx_state_q)
      StIdle: begin
        tx_txd_d = 1'b1;
        if (tx_ready_q && tx_axis_io.tvalid) begin
          tx_shift_d = tx_axis_io.tdata;
          tx_state_d = StStart;
          tx_cnt_d   = bit_len - CntW'(1);
          tx_txd_d   = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = StData;
          tx_cnt_d   = bit_len - CntW'(1);
          tx_idx_d   = '0;
          tx_txd_d   = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else begin
          tx_cnt_d = tx_cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = bit_len - CntW'(1);
          if (tx_idx_q == LastIdx) begin
            tx_state_d = StStop;
            tx_txd_d   = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + IdxW'(1);
            tx_txd_d   = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = StIdle;
          tx_busy_d  = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q - CntW'(1);
        end
      end
      default: tx_state_d = StIdle;
    endcase

    // Registered so tready stays low in the reset cycle and rises with busy falling.
    tx_ready_d = (tx_state_d == StIdle);
  end

  assign tx_axis_io.tready = tx_ready_q;
  assign txd_o             = tx_txd_q;
  assign tx_busy_o         = tx_busy_q;

  // ---------------------------------------------------------------------------------------------
  // Receiver input conditioning
  // ---------------------------------------------------------------------------------------------
  logic rx_in;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rxd_i};
    end
  end

  assign rx_in = rx_sync_q[1];
`else
  logic rx_in_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_in_q <= 1'b1;
    end else begin
      rx_in_q <= rxd_i;
    end
  end

  assign rx_in = rx_in_q;
`endif

  // ---------------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------------
  state_e               rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [IdxW-1:0]      rx_idx_q, rx_idx_d;
  logic [DataWidth-1:0] rx_shift_q, rx_shift_d;
  logic [DataWidth-1:0] rx_shift_in;
  logic                 rx_busy_q, rx_busy_d;
  logic [DataWidth-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_word_done;
  logic                 rx_handshake;

  // LSB arrives first, so each new bit enters at the top and shifts down.
  always_comb begin
    rx_shift_in                = rx_shift_q >> 1;
    rx_shift_in[DataWidth-1]   = rx_in;
  end

  assign rx_handshake = rx_valid_q && rx_axis_io.tready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q  <= StIdle;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_busy_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_busy_q   <= rx_busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_busy_d    = rx_busy_q;
    frame_err_d  = 1'b0;
    rx_word_done = 1'b0;

    unique case (rx_state_q)
      StIdle: begin
        if (!rx_in) begin
          rx_state_d = StStart;
          rx_cnt_d   = half_len - CntW'(1);
          rx_busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (rx_cnt_q == '0) begin
          if (rx_in) begin
            // Line went back high by mid-start: treat as noise.
            rx_state_d = StIdle;
            rx_busy_d  = 1'b0;
          end else begin
            rx_state_d = StData;
            rx_cnt_d   = bit_len - CntW'(1);
            rx_idx_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = rx_shift_in;
          rx_cnt_d   = bit_len - CntW'(1);
          if (rx_idx_q == LastIdx) begin
            rx_state_d = StStop;
          end else begin
            rx_idx_d = rx_idx_q + IdxW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = StIdle;
          rx_busy_d  = 1'b0;
          if (rx_in) begin
            rx_word_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Output word register. A completion in the same cycle as a handshake reloads the word
  // without flagging overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_handshake) begin
      rx_valid_d = 1'b0;
    end
    if (rx_word_done) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_handshake;
    end
  end

  assign rx_axis_io.tdata  = rx_data_q;
  assign rx_axis_io.tvalid = rx_valid_q;
  assign rx_busy_o         = rx_busy_q;
  assign overrun_error_o   = overrun_q;
  assign frame_error_o     = frame_err_q;

endmodule

// File: tb/tb_uart_axis_core.sv
// Self-checking bench for uart_axis_core: randomized TX frames checked bit-by-bit against an
// ideal frame model, loopback and directly driven RX frames checked through an expected-byte
// queue, plus error, glitch, prescale=0 and mid-frame reset scenarios.
module tb_uart_axis_core;

  localparam int unsigned DW = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] prescale;
  logic        txd;
  logic        tx_busy;
  logic        rxd;
  logic        rxd_drv;
  logic        loop_en;
  logic        rx_busy;
  logic        ovr;
  logic        ferr;

  uart_axis_core_if #(.DataWidth(DW)) tx_if ();
  uart_axis_core_if #(.DataWidth(DW)) rx_if ();

  assign rxd = loop_en ? txd : rxd_drv;

  uart_axis_core #(.DataWidth(DW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .prescale_i      (prescale),
    .tx_axis_io      (tx_if),
    .txd_o           (txd),
    .tx_busy_o       (tx_busy),
    .rxd_i           (rxd),
    .rx_axis_io      (rx_if),
    .rx_busy_o       (rx_busy),
    .overrun_error_o (ovr),
    .frame_error_o   (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ideal bit period and frame bit k (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic int bit_len(input logic [15:0] p);
    return ((p == 16'd0) ? 1 : int'(p)) * 8;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // RX scoreboard
  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;

  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovr)  ovr_cnt++;
    if (rx_if.tvalid && rx_if.tready) begin
      if (exp_q.size() == 0) check_eq("rx_expected_nonempty", 32'(exp_q.size()), 32'd1);
      else check_eq("rx_data", 32'(rx_if.tdata), 32'(exp_q.pop_front()));
    end
  end

  // Transmit one byte and check txd on every clock of the frame.
  task automatic send_tx(input logic [7:0] d);
    int bl;
    int w;
    bl = bit_len(prescale);
    w  = 0;
    while (!tx_if.tready && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check_eq("tx_ready_wait", 32'(tx_if.tready), 32'd1);
    tx_if.tdata  = d;
    tx_if.tvalid = 1'b1;
    if (loop_en) exp_q.push_back(d);
    for (int i = 0; i < 10 * bl; i++) begin
      @(negedge clk);
      // Stream activity during the frame must be ignored.
      tx_if.tvalid = (i == 10 * bl - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      tx_if.tdata  = 8'($urandom);
      check_eq("txd", 32'(txd), 32'(frame_bit(d, i / bl)));
      if (i % bl == 0) begin
        check_eq("tx_busy_during", 32'(tx_busy), 32'd1);
        check_eq("tx_ready_during", 32'(tx_if.tready), 32'd0);
      end
    end
    @(negedge clk);
    check_eq("tx_busy_after", 32'(tx_busy), 32'd0);
    check_eq("tx_ready_after", 32'(tx_if.tready), 32'd1);
    check_eq("txd_after", 32'(txd), 32'd1);
  endtask

  // Drive one frame directly on rxd; a low stop bit is shortened so the line is idle before
  // the receiver could mistake it for another start bit.
  task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
    int bl;
    bl = bit_len(prescale);
    if (stop_bit) exp_q.push_back(d);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = (k == 9) ? stop_bit : frame_bit(d, k);
      if (k == 9 && !stop_bit) begin
        repeat (bl / 2 + 2) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (bl - bl / 2 - 2) @(negedge clk);
      end else begin
        repeat (bl) @(negedge clk);
      end
      if (k == 1) check_eq("rx_busy_during", 32'(rx_busy), 32'd1);
    end
    rxd_drv = 1'b1;
    repeat (bl) @(negedge clk);
    check_eq("rx_busy_after", 32'(rx_busy), 32'd0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    prescale     = 16'd1;
    rxd_drv      = 1'b1;
    loop_en      = 1'b0;
    tx_if.tdata  = '0;
    tx_if.tvalid = 1'b0;
    rx_if.tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_if.tready), 32'd0);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_if.tvalid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_if.tdata), 32'd0);
    check_eq("rst_rx_busy", 32'(rx_busy), 32'd0);
    check_eq("rst_ferr", 32'(ferr), 32'd0);
    check_eq("rst_ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("tx_ready_before_edge", 32'(tx_if.tready), 32'd0);
    @(negedge clk);
    check_eq("tx_ready_after_release", 32'(tx_if.tready), 32'd1);
    check_eq("txd_after_release", 32'(txd), 32'd1);

    // TX 0xA5 at prescale 1, then random bytes/prescales
    send_tx(8'hA5);
    for (int n = 0; n < 4; n++) begin
      prescale = 16'($urandom_range(0, 3));
      send_tx(8'($urandom));
    end

    // Loopback, consumer always ready
    loop_en  = 1'b1;
    prescale = 16'd1;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    send_tx(8'h3C);
    send_tx(8'hC3);
    for (int n = 0; n < 5; n++) begin
      prescale = 16'($urandom_range(1, 3));
      send_tx(8'($urandom));
    end
    repeat (40) @(negedge clk);
    check_eq("loop_all_received", 32'(exp_q.size()), 32'd0);
    check_eq("loop_ferr", 32'(ferr_cnt), 32'd0);
    check_eq("loop_ovr", 32'(ovr_cnt), 32'd0);

    // Loopback overrun, consumer stalled
    prescale     = 16'd1;
    rx_if.tready = 1'b0;
    send_tx(8'h11);
    send_tx(8'h22);
    repeat (20) @(negedge clk);
    check_eq("ovr_pulse_count", 32'(ovr_cnt), 32'd1);
    check_eq("ovr_data", 32'(rx_if.tdata), 32'h22);
    check_eq("ovr_valid", 32'(rx_if.tvalid), 32'd1);
    check_eq("ovr_ferr", 32'(ferr_cnt), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h22);
    @(posedge clk);
    #1 rx_if.tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("ovr_valid_cleared", 32'(rx_if.tvalid), 32'd0);
    check_eq("ovr_word_taken", 32'(exp_q.size()), 32'd0);
    loop_en = 1'b0;

    // Directly driven RX frames: good frames, then a framing error
    ferr_cnt = 0;
    ovr_cnt  = 0;
    for (int n = 0; n < 4; n++) begin
      prescale = 16'($urandom_range(0, 3));
      drive_rx(8'($urandom), 1'b1);
    end
    check_eq("rx_direct_received", 32'(exp_q.size()), 32'd0);
    prescale = 16'd1;
    drive_rx(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("ferr_pulse_count", 32'(ferr_cnt), 32'd1);
    check_eq("ferr_valid", 32'(rx_if.tvalid), 32'd0);
    check_eq("ferr_ovr", 32'(ovr_cnt), 32'd0);

    // Short glitch is a false start
    prescale = 16'd2;
    ferr_cnt = 0;
    rxd_drv  = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("glitch_busy", 32'(rx_busy), 32'd1);
    repeat (48) @(negedge clk);
    check_eq("glitch_valid", 32'(rx_if.tvalid), 32'd0);
    check_eq("glitch_ferr", 32'(ferr_cnt), 32'd0);
    check_eq("glitch_busy_after", 32'(rx_busy), 32'd0);

    // prescale 0 behaves as prescale 1
    prescale = 16'd0;
    send_tx(8'($urandom));

    // Reset in the middle of a TX frame
    prescale     = 16'd1;
    tx_if.tdata  = 8'hF0;
    tx_if.tvalid = 1'b1;
    @(negedge clk);
    tx_if.tvalid = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("abort_txd_before", 32'(txd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_txd", 32'(txd), 32'd1);
    check_eq("abort_busy", 32'(tx_busy), 32'd0);
    check_eq("abort_ready", 32'(tx_if.tready), 32'd0);
    @(negedge clk);
    check_eq("abort_txd_held", 32'(txd), 32'd1);
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready_pre_edge", 32'(tx_if.tready), 32'd0);
    @(negedge clk);
    check_eq("abort_ready_release", 32'(tx_if.tready), 32'd1);
    send_tx(8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
